// File: rtl/instr_exec.sv
// instr_exec: single-issue accumulator execution stage.
//
// Accepts one 16-bit instruction per handshake ([15:13] opcode, [12] AM,
// [11:8] reserved, [7:0] operand) and runs it through IDLE -> DECODE ->
// (FETCH) -> EXEC. The result appears on acc the cycle the block returns
// to IDLE. Opcode 111 parks the FSM in HALT until reset.
//
// Optional feature: define INSTR_EXEC_DIRECT_EN to build the 16x8 register
// file, the FETCH state, direct addressing (AM=1) and STORE. Without it AM
// is ignored and STORE behaves as NOP.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   instrWord    instruction word from the upstream stage
//   instr_valid  instrWord is valid this cycle
//   instr_ready  block accepts an instruction this cycle (IDLE only)
//   acc          accumulator
//   zero_flag    acc == 0 after the last ALU operation
//   carry_flag   carry/borrow from the last ADD/SUB
//   busy         FSM neither in IDLE nor in HALT
//   halted       FSM in HALT
module instr_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instrWord,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  acc,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {StIdle, StDecode, StFetch, StExec, StHalt} state_e;

    state_e      r_state;
    logic [2:0]  r_opcode;
    logic [7:0]  r_operand;
    logic [7:0]  r_acc;
    logic        r_zero;
    logic        r_carry;
    logic        r_ready;
    logic        r_busy;
    logic        r_halted;

    logic [7:0]  w_op;
    logic [7:0]  w_result;
    logic        w_carry;
    logic        w_alu_op;
    logic [8:0]  w_sum;

`ifdef INSTR_EXEC_DIRECT_EN
    logic        r_am;
    logic [7:0]  r_fetched;
    logic [7:0]  r_regfile [16];
    logic        w_needs_fetch;
    logic        w_unused;

    assign w_unused      = ^instrWord[11:8];
    // Only data-consuming opcodes (LOAD..OR) honour direct addressing.
    assign w_needs_fetch = r_am && w_alu_op;
    assign w_op          = w_needs_fetch ? r_fetched : r_operand;
`else
    logic        w_unused;

    assign w_unused = ^instrWord[12:8];
    assign w_op     = r_operand;
`endif

    assign w_alu_op = (r_opcode >= 3'd1) && (r_opcode <= 3'd5);
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_op};

    always_comb begin
        w_result = r_acc;
        w_carry  = r_carry;
        case (r_opcode)
            3'b001: w_result = w_op;
            3'b010: {w_carry, w_result} = w_sum;
            3'b011: begin
                w_result = r_acc - w_op;
                w_carry  = (w_op > r_acc);
            end
            3'b100: w_result = r_acc & w_op;
            3'b101: w_result = r_acc | w_op;
            default: begin
                w_result = r_acc;
                w_carry  = r_carry;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_opcode  <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_zero    <= 1'b1;
            r_carry   <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
`ifdef INSTR_EXEC_DIRECT_EN
            r_am      <= 1'b0;
            r_fetched <= '0;
            for (int i = 0; i < 16; i++) begin
                r_regfile[i] <= '0;
            end
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (instr_valid) begin
                        r_opcode  <= instrWord[15:13];
                        r_operand <= instrWord[7:0];
`ifdef INSTR_EXEC_DIRECT_EN
                        r_am      <= instrWord[12];
`endif
                        r_state   <= StDecode;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                StDecode: begin
`ifdef INSTR_EXEC_DIRECT_EN
                    r_state <= w_needs_fetch ? StFetch : StExec;
`else
                    r_state <= StExec;
`endif
                end
`ifdef INSTR_EXEC_DIRECT_EN
                StFetch: begin
                    r_fetched <= r_regfile[r_operand[3:0]];
                    r_state   <= StExec;
                end
`endif
                StExec: begin
                    r_acc   <= w_result;
                    r_carry <= w_carry;
                    if (w_alu_op) begin
                        r_zero <= (w_result == 8'd0);
                    end
`ifdef INSTR_EXEC_DIRECT_EN
                    if (r_opcode == 3'b110) begin
                        r_regfile[r_operand[3:0]] <= r_acc;
                    end
`endif
                    r_busy <= 1'b0;
                    if (r_opcode == 3'b111) begin
                        r_state  <= StHalt;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                        r_ready <= 1'b1;
                    end
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign acc         = r_acc;
    assign zero_flag   = r_zero;
    assign carry_flag  = r_carry;
    assign busy        = r_busy;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_exec.sv
// Self-checking bench for instr_exec: directed scenarios plus randomized
// instruction streams checked against an architectural model.
module tb_instr_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instrWord;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  acc;
    logic        zero_flag;
    logic        carry_flag;
    logic        busy;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    logic [7:0] m_acc;
    logic       m_z;
    logic       m_c;
    logic [7:0] m_rf [16];

    instr_exec dut (
        .clk         (clk),
        .reset       (reset),
        .instrWord   (instrWord),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .acc         (acc),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_acc = 8'd0;
        m_z   = 1'b1;
        m_c   = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 8'd0;
    endtask

    // Architectural effect of one instruction; returns latency in cycles.
    task automatic model_exec(input logic [15:0] w, output int lat);
        logic [2:0] opc;
        logic [7:0] op;
        int         tmp;
        opc = w[15:13];
        op  = w[7:0];
        lat = 3;
`ifdef INSTR_EXEC_DIRECT_EN
        if (w[12] && opc >= 3'd1 && opc <= 3'd5) begin
            op  = m_rf[w[3:0]];
            lat = 4;
        end
`endif
        case (opc)
            3'd1: m_acc = op;
            3'd2: begin
                tmp   = int'(m_acc) + int'(op);
                m_c   = (tmp > 255);
                m_acc = 8'(tmp);
            end
            3'd3: begin
                m_c   = (int'(op) > int'(m_acc));
                m_acc = 8'(int'(m_acc) - int'(op) + 256);
            end
            3'd4: m_acc = m_acc & op;
            3'd5: m_acc = m_acc | op;
            3'd6: begin
`ifdef INSTR_EXEC_DIRECT_EN
                m_rf[w[3:0]] = m_acc;
`endif
            end
            default: ;
        endcase
        if (opc >= 3'd1 && opc <= 3'd5) m_z = (m_acc == 8'd0);
    endtask

    // Issue one instruction from IDLE and check timing and final state.
    // Entered and left at 1 time unit after a rising edge.
    task automatic exec_instr(input logic [15:0] w);
        logic [7:0] old_acc;
        logic       exp_halt;
        int         lat;
        old_acc     = m_acc;
        exp_halt    = (w[15:13] == 3'b111);
        instrWord   = w;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        model_exec(w, lat);
        // Garbage while busy must not matter.
        instr_valid = 1'($urandom_range(0, 1));
        instrWord   = 16'($urandom);
        for (int k = 0; k < lat - 1; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            n_checks++;
            if (instr_ready !== 1'b0 || busy !== 1'b1 || acc !== old_acc) begin
                n_fail++;
                $display("FAIL exec_busy w=%h k=%0d got rdy=%b busy=%b acc=%h exp rdy=0 busy=1 acc=%h",
                         w, k, instr_ready, busy, acc, old_acc);
            end
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n_checks++;
        if (acc !== m_acc || zero_flag !== m_z || carry_flag !== m_c) begin
            n_fail++;
            $display("FAIL exec_result w=%h got acc=%h z=%b c=%b exp acc=%h z=%b c=%b",
                     w, acc, zero_flag, carry_flag, m_acc, m_z, m_c);
        end
        n_checks++;
        if (instr_ready !== !exp_halt || busy !== 1'b0 || halted !== exp_halt) begin
            n_fail++;
            $display("FAIL exec_status w=%h got rdy=%b busy=%b halted=%b exp rdy=%b busy=0 halted=%b",
                     w, instr_ready, busy, halted, !exp_halt, exp_halt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset       = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_idle_reset_state(input string nm);
        n_checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || halted !== 1'b0 || acc !== 8'h00 ||
            zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got rdy=%b busy=%b halted=%b acc=%h z=%b c=%b exp 1 0 0 00 1 0",
                     nm, instr_ready, busy, halted, acc, zero_flag, carry_flag);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle_reset_state("reset_first_cycle");
        @(posedge clk); #1;
        check_idle_reset_state("reset_idle_hold");
    endtask

    task automatic test_directed_alu();
        exec_instr(16'h2005);
        n_checks++;
        if (acc !== 8'h05 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL load_imm got acc=%h z=%b c=%b exp 05 0 0", acc, zero_flag, carry_flag);
        end
        exec_instr(16'h20F0);
        exec_instr(16'h4020);
        n_checks++;
        if (acc !== 8'h10 || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL add_carry got acc=%h z=%b c=%b exp 10 0 1", acc, zero_flag, carry_flag);
        end
        exec_instr(16'h2003);
        exec_instr(16'h6003);
        n_checks++;
        if (acc !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_zero got acc=%h z=%b c=%b exp 00 1 0", acc, zero_flag, carry_flag);
        end
        exec_instr(16'h6001);
        n_checks++;
        if (acc !== 8'hFF || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow got acc=%h z=%b c=%b exp FF 0 1", acc, zero_flag, carry_flag);
        end
    endtask

    task automatic test_store_direct();
        logic [7:0] exp_acc;
`ifdef INSTR_EXEC_DIRECT_EN
        exp_acc = 8'h5A;
`else
        exp_acc = 8'h07;
`endif
        exec_instr(16'h205A);
        exec_instr(16'hC007);
        exec_instr(16'h2000);
        exec_instr(16'h3007);
        n_checks++;
        if (acc !== exp_acc) begin
            n_fail++;
            $display("FAIL store_direct_load got acc=%h exp %h", acc, exp_acc);
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int n = 0; n < 200; n++) begin
            w = {3'($urandom_range(0, 6)), 13'($urandom)};
            exec_instr(w);
        end
    endtask

    task automatic test_back_to_back();
        // Second instruction offered on the very cycle ready returns.
        exec_instr(16'h2081);
        exec_instr(16'h4081);
        n_checks++;
        if (acc !== 8'h02 || carry_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back got acc=%h c=%b exp 02 1", acc, carry_flag);
        end
    endtask

    task automatic test_halt();
        logic [7:0] held;
        exec_instr(16'h2033);
        held = m_acc;
        exec_instr(16'hE000);
        instr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            instrWord = 16'h2000 | 16'($urandom_range(0, 255));
            @(posedge clk); #1;
            n_checks++;
            if (halted !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b0 || acc !== held) begin
                n_fail++;
                $display("FAIL halt_hold k=%0d got halted=%b rdy=%b busy=%b acc=%h exp 1 0 0 %h",
                         k, halted, instr_ready, busy, acc, held);
            end
        end
        instr_valid = 1'b0;
        do_reset();
        check_idle_reset_state("halt_reset");
    endtask

    task automatic test_reset_mid();
        exec_instr(16'h20F0);
        instrWord   = 16'h40FF;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        reset       = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_idle_reset_state("reset_mid_decode");
        repeat (4) @(posedge clk);
        #1;
        check_idle_reset_state("reset_mid_no_add");
        // Reset beats an accept in the same cycle.
        instrWord   = 16'h2042;
        instr_valid = 1'b1;
        reset       = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        instr_valid = 1'b0;
        check_idle_reset_state("reset_vs_accept");
        repeat (4) @(posedge clk);
        #1;
        check_idle_reset_state("reset_vs_accept_dropped");
    endtask

    initial begin
        reset       = 1'b1;
        instrWord   = 16'h0000;
        instr_valid = 1'b0;
        model_reset();
        test_reset();
        test_directed_alu();
        test_store_direct();
        test_back_to_back();
        test_random();
        test_halt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
